riu2_histogram: RTL and testbench



---
 rtl/riu2_histogram.sv | 162 ++++++++++++++++
 tb/tb_riu2_histogram.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riu2_histogram.sv
// -----------------------------------------------------------------------------
// riu2_histogram
//   Consumer end of the riu2 code stream from the NIRD mapping stage. Builds a
//   10-bin histogram of riu2 codes (0..8 uniform patterns, 9 non-uniform) over
//   one frame. At end of frame the bins are drained downstream one per beat
//   over a valid/ready handshake. Each bin is cleared as it is read. The block
//   then re-arms for the next frame.
//
//   Optional build macro: RIU2_HIST_TOTAL_EN
//     Adds a saturating total counter (COUNT_W+4 bits) of all legal codes.
//     The total is presented as an 11th beat with bin_idx_o = 10.
//
// Ports
//   clk              clock
//   rst              synchronous active-high reset
//   done_i           data_i valid strobe, one code per cycle
//   data_i[3:0]      riu2 code, legal range 0..9
//   progress_done_i  single-cycle end-of-frame pulse
//   bin_ready_i      downstream accepts the presented bin
//   bin_valid_o      bin_idx_o / bin_count_o valid
//   bin_idx_o[3:0]   index of the presented bin
//   bin_count_o      count of the presented bin (COUNT_W bits)
//   hist_done_o      one-cycle pulse after the last beat is accepted
//   busy_o           high while draining
//   err_o            sticky: illegal code seen, or a sample dropped during drain
// -----------------------------------------------------------------------------
module riu2_histogram #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               done_i,
  input  logic [3:0]         data_i,
  input  logic               progress_done_i,
  input  logic               bin_ready_i,
  output logic               bin_valid_o,
  output logic [3:0]         bin_idx_o,
  output logic [COUNT_W-1:0] bin_count_o,
  output logic               hist_done_o,
  output logic               busy_o,
  output logic               err_o
);

  typedef enum logic {S_ACCUM, S_DRAIN} state_t;

  localparam int NBINS = 10;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
`ifdef RIU2_HIST_TOTAL_EN
  localparam logic [3:0] LAST_IDX = 4'd10;
`else
  localparam logic [3:0] LAST_IDX = 4'd9;
`endif

  state_t             r_state;
  state_t             w_next_state;
  logic [COUNT_W-1:0] r_bins [NBINS];
  logic [3:0]         r_idx;
  logic               r_hist_done;
  logic               r_err;
  logic [COUNT_W-1:0] w_bin_count;
  logic               w_sample;
  logic               w_code_ok;
  logic               w_accept;
  logic               w_last;
  logic               w_err_set;

  // Samples are only taken while accumulating; in DRAIN they are dropped.
  assign w_sample  = (r_state == S_ACCUM) && done_i;
  assign w_code_ok = (data_i <= 4'd9);
  assign w_accept  = (r_state == S_DRAIN) && bin_ready_i;
  assign w_last    = w_accept && (r_idx == LAST_IDX);
  assign w_err_set = (w_sample && !w_code_ok) || ((r_state == S_DRAIN) && done_i);

  // Next-state logic
  always_comb begin
    // NOTE: default assigned first so every path drives w_next_state (no latch).
    w_next_state = r_state;
    case (r_state)
      S_ACCUM: if (progress_done_i) w_next_state = S_DRAIN;
      S_DRAIN: if (w_last)          w_next_state = S_ACCUM;
      default:                      w_next_state = S_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) r_state <= S_ACCUM;
    else     r_state <= w_next_state;
  end

`ifdef RIU2_HIST_TOTAL_EN
  localparam int TOT_W = COUNT_W + 4;
  localparam logic [TOT_W-1:0] TOT_MAX = '1;
  logic [TOT_W-1:0] r_total;

  always_ff @(posedge clk) begin
    if (rst)
      r_total <= '0;
    else if (w_accept && (r_idx == 4'd10))
      r_total <= '0;
    else if (w_sample && w_code_ok && (r_total != TOT_MAX))
      r_total <= r_total + TOT_W'(1);
  end
`endif

  // Zero-latency read of the registered bin array for the presented beat.
  always_comb begin
    // NOTE: blocking assignments inside always_comb; later matches override
    // the default, which gives a plain priority mux.
    w_bin_count = '0;
    if (r_state == S_DRAIN) begin
      for (int i = 0; i < NBINS; i++)
        if (r_idx == 4'(i)) w_bin_count = r_bins[i];
`ifdef RIU2_HIST_TOTAL_EN
      if (r_idx == 4'd10)
        w_bin_count = (r_total > {4'b0000, CNT_MAX}) ? CNT_MAX : r_total[COUNT_W-1:0];
`endif
    end
  end

  // Bin array. A beat acceptance clears its bin. Samples and acceptances never
  // coincide because they belong to different states.
  always_ff @(posedge clk) begin
    // NOTE: the bins are reset explicitly. A reset mid-drain must leave a clean
    // histogram, so this array cannot be treated as an unreset memory.
    if (rst) begin
      for (int i = 0; i < NBINS; i++) r_bins[i] <= '0;
    end else begin
      for (int i = 0; i < NBINS; i++) begin
        if (w_accept && (r_idx == 4'(i)))
          r_bins[i] <= '0;
        else if (w_sample && (data_i == 4'(i)) && (r_bins[i] != CNT_MAX))
          r_bins[i] <= r_bins[i] + COUNT_W'(1);
      end
    end
  end

  // Beat index, end-of-drain pulse, sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_hist_done <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_hist_done <= w_last;
      if (w_err_set) r_err <= 1'b1;
      if ((r_state == S_ACCUM) && progress_done_i)
        r_idx <= '0;
      else if (w_accept)
        r_idx <= w_last ? 4'd0 : r_idx + 4'd1;
    end
  end

  assign bin_valid_o = (r_state == S_DRAIN);
  assign busy_o      = (r_state == S_DRAIN);
  assign bin_idx_o   = r_idx;
  assign bin_count_o = w_bin_count;
  assign hist_done_o = r_hist_done;
  assign err_o       = r_err;

endmodule

// File: tb/tb_riu2_histogram.sv
// -----------------------------------------------------------------------------
// tb_riu2_histogram
//   Drives two instances from one stimulus stream. u_dut uses COUNT_W=16 and
//   u_sat uses COUNT_W=2, so saturation shows up with only a few samples.
//   The reference model counts codes per frame with plain integers. At end of
//   frame it pushes the expected beats into a scoreboard queue, and a monitor
//   pops and compares on every accepted beat.
// -----------------------------------------------------------------------------
module tb_riu2_histogram;

`ifdef RIU2_HIST_TOTAL_EN
  localparam int LAST = 10;
`else
  localparam int LAST = 9;
`endif
  localparam int BIG_MAX   = 65535;
  localparam int SMALL_MAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        done_i;
  logic [3:0]  data_i;
  logic        progress_done_i;
  logic        bin_ready_i;

  logic        bin_valid_o, hist_done_o, busy_o, err_o;
  logic [3:0]  bin_idx_o;
  logic [15:0] bin_count_o;
  logic        s_valid, s_done, s_busy, s_err;
  logic [3:0]  s_idx;
  logic [1:0]  s_count;

  riu2_histogram #(.COUNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .done_i(done_i), .data_i(data_i),
    .progress_done_i(progress_done_i), .bin_ready_i(bin_ready_i),
    .bin_valid_o(bin_valid_o), .bin_idx_o(bin_idx_o), .bin_count_o(bin_count_o),
    .hist_done_o(hist_done_o), .busy_o(busy_o), .err_o(err_o)
  );

  riu2_histogram #(.COUNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .done_i(done_i), .data_i(data_i),
    .progress_done_i(progress_done_i), .bin_ready_i(bin_ready_i),
    .bin_valid_o(s_valid), .bin_idx_o(s_idx), .bin_count_o(s_count),
    .hist_done_o(s_done), .busy_o(s_busy), .err_o(s_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int cnt;
    int cnt_s;
  } beat_t;

  beat_t sb_q[$];
  int    m_bins[10];
  int    m_total;
  bit    exp_err;
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 10; i++) m_bins[i] = 0;
    m_total = 0;
  endfunction

  // End of frame: the expected drain is every bin in index order, then the total.
  function automatic void push_frame();
    for (int i = 0; i < 10; i++)
      sb_q.push_back('{i, min_i(m_bins[i], BIG_MAX), min_i(m_bins[i], SMALL_MAX)});
`ifdef RIU2_HIST_TOTAL_EN
    sb_q.push_back('{10, min_i(m_total, BIG_MAX), min_i(m_total, SMALL_MAX)});
`endif
    model_clear();
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: compares accepted beats against the scoreboard. It also checks that
  // outputs hold during stalls and that hist_done_o follows the last beat.
  // ---------------------------------------------------------------------------
  bit          pend_done  = 1'b0;
  bit          prev_stall = 1'b0;
  logic [3:0]  prev_idx;
  logic [15:0] prev_cnt;

  always @(negedge clk) begin
    if (rst) begin
      pend_done  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (pend_done || hist_done_o || s_done) begin
        check("hist_done", {30'd0, s_done, hist_done_o}, {30'd0, pend_done, pend_done});
        pend_done = 1'b0;
      end
      if (prev_stall) begin
        check("stall_valid", bin_valid_o, 1'b1);
        check("stall_idx", bin_idx_o, prev_idx);
        check("stall_cnt", bin_count_o, prev_cnt);
      end
      if (bin_valid_o && bin_ready_i) begin
        if (sb_q.size() == 0) begin
          fail("unexpected_beat");
        end else begin
          beat_t e;
          e = sb_q.pop_front();
          check("beat_idx", bin_idx_o, e.idx);
          check("beat_cnt", bin_count_o, e.cnt);
          check("sat_valid", s_valid, 1'b1);
          check("sat_idx", s_idx, e.idx);
          check("sat_cnt", s_count, e.cnt_s);
          if (e.idx == LAST) pend_done = 1'b1;
        end
      end
      prev_stall = bin_valid_o && !bin_ready_i;
      prev_idx   = bin_idx_o;
      prev_cnt   = bin_count_o;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int code, input bit vld, input bit pd);
    done_i          = vld;
    data_i          = 4'(code);
    progress_done_i = pd;
    if (vld) begin
      if (code <= 9) begin
        m_bins[code]++;
        m_total++;
      end else begin
        exp_err = 1'b1;
      end
    end
    if (pd) push_frame();
    step();
    done_i          = 1'b0;
    progress_done_i = 1'b0;
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready.
  // poke: drive random done_i during the drain; those samples must be dropped.
  task automatic drain(input int mode, input bit poke);
    int k;
    k = 0;
    do begin
      case (mode)
        0:       bin_ready_i = 1'b1;
        1:       bin_ready_i = ((k % 4) == 0) || ((k % 4) == 3);
        default: bin_ready_i = 1'($urandom_range(0, 1));
      endcase
      if (poke) begin
        done_i = 1'($urandom_range(0, 1));
        data_i = 4'($urandom_range(0, 9));
        if (done_i) exp_err = 1'b1;
        progress_done_i = 1'($urandom_range(0, 1));
      end
      step();
      k++;
    end while (busy_o && k < 400);
    done_i          = 1'b0;
    progress_done_i = 1'b0;
    bin_ready_i     = 1'b0;
    if (busy_o) fail("drain_timeout");
    step();
    check("sb_drained", sb_q.size(), 0);
    check("err_state", err_o, exp_err);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb_q.delete();
    model_clear();
    exp_err = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  initial begin
    int codes1[7] = '{0, 1, 1, 9, 9, 9, 4};
    rst = 1'b1; done_i = 1'b0; data_i = '0; progress_done_i = 1'b0; bin_ready_i = 1'b0;
    model_clear();
    exp_err = 1'b0;
    repeat (3) step();
    check("rst_valid", bin_valid_o, 1'b0);
    check("rst_idx", bin_idx_o, 4'd0);
    check("rst_cnt", bin_count_o, 16'd0);
    check("rst_done", hist_done_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    rst = 1'b0;
    step();

    // Directed frame, then an empty frame to show that every bin was cleared.
    foreach (codes1[i]) send(codes1[i], 1'b1, 1'b0);
    send(0, 1'b0, 1'b1);
    check("busy_after_pd", busy_o, 1'b1);
    drain(0, 1'b0);
    send(0, 1'b0, 1'b1);
    drain(0, 1'b0);

    // Final code in the same cycle as progress_done_i.
    send(2, 1'b1, 1'b0);
    send(5, 1'b1, 1'b1);
    check("valid_latency", bin_valid_o, 1'b1);
    check("idx_first", bin_idx_o, 4'd0);
    drain(0, 1'b0);

    // Stalling drain (ready 1,0,0,1); five code-3 samples saturate the 2-bit copy.
    repeat (5) send(3, 1'b1, 1'b0);
    send(7, 1'b1, 1'b0);
    send(0, 1'b0, 1'b1);
    drain(1, 1'b0);

    // Random frames with random ready.
    for (int f = 0; f < 6; f++) begin
      int n;
      n = $urandom_range(0, 40);
      for (int j = 0; j < n; j++)
        send($urandom_range(0, 9), 1'($urandom_range(0, 3) != 0), 1'b0);
      send($urandom_range(0, 9), 1'($urandom_range(0, 1)), 1'b1);
      drain(2, 1'b0);
    end

    // Reset while beat 4 is presented, then an empty frame drains zeros.
    foreach (codes1[i]) send(codes1[i], 1'b1, 1'b0);
    send(0, 1'b0, 1'b1);
    bin_ready_i = 1'b1;
    for (int k = 0; k < 20 && bin_idx_o != 4'd4; k++) step();
    check("reached_idx4", bin_idx_o, 4'd4);
    rst = 1'b1;
    sb_q.delete();
    model_clear();
    exp_err = 1'b0;
    step();
    check("abort_valid", bin_valid_o, 1'b0);
    check("abort_busy", busy_o, 1'b0);
    rst = 1'b0;
    bin_ready_i = 1'b0;
    step();
    send(0, 1'b0, 1'b1);
    drain(0, 1'b0);

    // done_i during drain: samples dropped, err_o set and sticky.
    send(6, 1'b1, 1'b0);
    send(6, 1'b1, 1'b0);
    send(0, 1'b0, 1'b1);
    drain(0, 1'b1);
    check("err_drain", err_o, 1'b1);
    send(1, 1'b1, 1'b1);
    drain(0, 1'b0);
    check("err_sticky", err_o, 1'b1);
    do_reset();
    check("err_cleared", err_o, 1'b0);

    // Illegal code 12: ignored for counting, err_o set.
    send(8, 1'b1, 1'b0);
    send(12, 1'b1, 1'b0);
    check("err_illegal", err_o, 1'b1);
    send(8, 1'b1, 1'b1);
    drain(2, 1'b0);

    check("sb_final", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
